// File: rtl/axi_mem_pkg.sv
// Shared types for the axi_mem_router behavioural AXI4 memory slave:
// bus widths, write/read FSM state encodings and the latched burst descriptor.
package axi_mem_pkg;

  localparam int AXI_ADDR_W = 64;
  localparam int DATA_W     = 256;
  localparam int STRB_W     = DATA_W / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [7:0]            beat;
  } burst_t;

endpackage

// File: rtl/axi_mem_beat_addr.sv
// Incrementing-burst beat address (start + beat * 2**size, no 4K wrap) and
// last-beat flag; one instance per channel.
module axi_mem_beat_addr
  import axi_mem_pkg::*;
(
  input  burst_t                burst,
  output logic [AXI_ADDR_W-1:0] beat_addr,
  output logic                  last
);

  assign beat_addr = burst.addr + (AXI_ADDR_W'(burst.beat) << burst.size);
  assign last      = (burst.beat == burst.len);

endmodule

// File: rtl/axi_mem_router.sv
// Behavioural AXI4 memory slave: 2**MEM_AW byte store `mem`, independent write and read FSMs.
// Optional AXI_MEM_ROUTER_PRELOAD_EN: time-0 pattern fill.
module axi_mem_router #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 256,
  parameter int MEM_AW = 21,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m_axi_awvalid,
  output logic                m_axi_awready,
  input  logic [ADDR_W-1:0]   m_axi_awaddr,
  input  logic [7:0]          m_axi_awlen,
  input  logic [2:0]          m_axi_awsize,
  input  logic                m_axi_wvalid,
  output logic                m_axi_wready,
  input  logic [DATA_W-1:0]   m_axi_wdata,
  input  logic [DATA_W/8-1:0] m_axi_wstrb,
  input  logic                m_axi_wlast,
  output logic                m_axi_bvalid,
  input  logic                m_axi_bready,
  input  logic                m_axi_arvalid,
  output logic                m_axi_arready,
  input  logic [ADDR_W-1:0]   m_axi_araddr,
  input  logic [7:0]          m_axi_arlen,
  input  logic [2:0]          m_axi_arsize,
  output logic                m_axi_rvalid,
  input  logic                m_axi_rready,
  output logic [DATA_W-1:0]   m_axi_rdata,
  output logic                m_axi_rlast
);
  import axi_mem_pkg::*;

  localparam int         LANES     = DATA_W / 8;
  localparam int         MEM_BYTES = 2 ** MEM_AW;
  localparam logic [7:0] WAIT_INIT = 8'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  logic [7:0] mem [0:MEM_BYTES-1];

  wr_state_e             wr_state_reg, wr_state_next;
  burst_t                wr_burst_reg, wr_burst_next;
  logic [AXI_ADDR_W-1:0] wr_beat_addr;
  logic                  wr_last;
  logic                  wr_fire;

  rd_state_e             rd_state_reg, rd_state_next;
  burst_t                rd_burst_reg, rd_burst_next, launch_burst;
  logic [7:0]            wait_cnt_reg, wait_cnt_next;
  logic [AXI_ADDR_W-1:0] launch_addr;
  logic                  launch, launch_last;
  logic [DATA_W-1:0]     launch_data, rdata_reg;
  logic                  rlast_reg;

  axi_mem_beat_addr u_wr_addr (.burst(wr_burst_reg), .beat_addr(wr_beat_addr), .last(wr_last));
  axi_mem_beat_addr u_rd_addr (.burst(launch_burst), .beat_addr(launch_addr), .last(launch_last));

  // Readies are gated by rst_n so every output is low while reset is held.
  assign m_axi_awready = rst_n && (wr_state_reg == W_IDLE);
  assign m_axi_wready  = (wr_state_reg == W_DATA);
  assign m_axi_bvalid  = (wr_state_reg == W_RESP);
  assign m_axi_arready = rst_n && (rd_state_reg == R_IDLE);
  assign m_axi_rvalid  = (rd_state_reg == R_DATA);
  assign m_axi_rdata   = rdata_reg;
  assign m_axi_rlast   = rlast_reg;
  assign wr_fire       = rst_n && m_axi_wready && m_axi_wvalid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_reg <= W_IDLE;
      wr_burst_reg <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_burst_reg <= wr_burst_next;
    end
  end

  // Beat count alone ends the burst; wlast is deliberately ignored.
  always_comb begin
    wr_state_next = wr_state_reg;
    wr_burst_next = wr_burst_reg;
    case (wr_state_reg)
      W_IDLE: if (m_axi_awvalid) begin
        wr_burst_next = '{addr: AXI_ADDR_W'(m_axi_awaddr), len: m_axi_awlen,
                          size: m_axi_awsize, beat: 8'd0};
        wr_state_next = W_DATA;
      end
      W_DATA: if (m_axi_wvalid) begin
        if (wr_last) wr_state_next = W_RESP;
        else         wr_burst_next.beat = wr_burst_reg.beat + 8'd1;
      end
      W_RESP: if (m_axi_bready) wr_state_next = W_IDLE;
      default: wr_state_next = W_IDLE;
    endcase
  end

  // Lanes are placed relative to the beat address, so unaligned starts shift data.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (m_axi_wstrb[i]) mem[MEM_AW'(wr_beat_addr + AXI_ADDR_W'(i))] <= m_axi_wdata[8*i +: 8];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_rd_lane
      assign launch_data[8*gi +: 8] = mem[MEM_AW'(launch_addr + AXI_ADDR_W'(gi))];
    end
  endgenerate

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_burst_next = rd_burst_reg;
    wait_cnt_next = wait_cnt_reg;
    launch        = 1'b0;
    case (rd_state_reg)
      R_IDLE: if (m_axi_arvalid) begin
        rd_burst_next = '{addr: AXI_ADDR_W'(m_axi_araddr), len: m_axi_arlen,
                          size: m_axi_arsize, beat: 8'd0};
        if (RD_LAT <= 1) begin
          launch        = 1'b1;
          rd_state_next = R_DATA;
        end else begin
          wait_cnt_next = WAIT_INIT;
          rd_state_next = R_WAIT;
        end
      end
      R_WAIT: if (wait_cnt_reg == 8'd0) begin
        launch        = 1'b1;
        rd_state_next = R_DATA;
      end else begin
        wait_cnt_next = wait_cnt_reg - 8'd1;
      end
      R_DATA: if (m_axi_rready) begin
        if (rlast_reg) begin
          rd_state_next = R_IDLE;
        end else begin
          rd_burst_next.beat = rd_burst_reg.beat + 8'd1;
          launch             = 1'b1;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
    launch_burst = rd_burst_next;
  end

  // rdata/rlast only load on a beat launch, which keeps them stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_reg <= R_IDLE;
      rd_burst_reg <= '0;
      wait_cnt_reg <= '0;
      rdata_reg    <= '0;
      rlast_reg    <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_burst_reg <= rd_burst_next;
      wait_cnt_reg <= wait_cnt_next;
      if (launch) begin
        rdata_reg <= launch_data;
        rlast_reg <= launch_last;
      end
    end
  end

`ifdef AXI_MEM_ROUTER_PRELOAD_EN
  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'(i) ^ 8'(i >> 8);
  end
`endif

endmodule

// File: tb/tb_axi_mem_router.sv
// Randomized self-checking bench for axi_mem_router against a byte-level store model.
module tb_axi_mem_router;

  localparam int              MEM_AW = 21;
  localparam longint unsigned MASK   = (64'd1 << MEM_AW) - 64'd1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m_axi_awvalid, m_axi_awready;
  logic [63:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic         m_axi_wvalid, m_axi_wready;
  logic [255:0] m_axi_wdata;
  logic [31:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_bvalid, m_axi_bready;
  logic         m_axi_arvalid, m_axi_arready;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic         m_axi_rvalid, m_axi_rready;
  logic [255:0] m_axi_rdata;
  logic         m_axi_rlast;

  always #5 clk = ~clk;

  axi_mem_router #(.ADDR_W(64), .DATA_W(256), .MEM_AW(MEM_AW), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0]   model [longint unsigned];
  logic [255:0] wr_data_q[$];
  logic [31:0]  wr_strb_q[$];
  logic [255:0] rd_q[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [5:0] ctl_outs();
    return {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast};
  endfunction

  task automatic model_write(input longint unsigned ba, input logic [255:0] d, input logic [31:0] s);
    for (int i = 0; i < 32; i++)
      if (s[i]) model[(ba + longint'(i)) & MASK] = d[8*i +: 8];
  endtask

  task automatic model_expect(input longint unsigned a, output logic [255:0] exp, output logic [255:0] msk);
    exp = '0;
    msk = '0;
    for (int i = 0; i < 32; i++) begin
      longint unsigned k;
      k = (a + longint'(i)) & MASK;
      if (model.exists(k)) begin
        exp[8*i +: 8] = model[k];
        msk[8*i +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic hier_beat(input longint unsigned a, output logic [255:0] v);
    for (int i = 0; i < 32; i++) begin
      logic [MEM_AW-1:0] k;
      k = MEM_AW'(a + longint'(i));
      v[8*i +: 8] = dut.mem[k];
    end
  endtask

  task automatic axi_write(input longint unsigned addr, input int len, input int size,
                           input int bstall, input bit upd);
    int n;
    $display("WR addr=%h len=%0d size=%0d bstall=%0d", addr, len, size, bstall);
    m_axi_awaddr = addr; m_axi_awlen = 8'(len); m_axi_awsize = 3'(size); m_axi_awvalid = 1'b1;
    n = 0;
    while (!m_axi_awready && n < 50) begin @(posedge clk); #1; n++; end
    check("aw_ready", 256'(m_axi_awready), 256'(1));
    @(posedge clk); #1;
    m_axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      m_axi_wdata = wr_data_q[b]; m_axi_wstrb = wr_strb_q[b];
      m_axi_wlast = (b == len); m_axi_wvalid = 1'b1;
      n = 0;
      while (!m_axi_wready && n < 50) begin @(posedge clk); #1; n++; end
      if (!m_axi_wready) check("w_ready_timeout", 256'(m_axi_wready), 256'(1));
      @(posedge clk);
      if (upd) model_write(addr + (longint'(b) << size), wr_data_q[b], wr_strb_q[b]);
      #1;
      m_axi_wvalid = 1'b0; m_axi_wlast = 1'b0;
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    n = 0;
    while (!m_axi_bvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("bvalid", 256'(m_axi_bvalid), 256'(1));
    for (int k = 0; k < bstall; k++) begin
      @(posedge clk); #1;
      check("bvalid_hold", 256'(m_axi_bvalid), 256'(1));
      check("awready_busy", 256'(m_axi_awready), 256'(0));
    end
    m_axi_bready = 1'b1;
    @(posedge clk); #1;
    m_axi_bready = 1'b0;
    check("bvalid_pulse", 256'(m_axi_bvalid), 256'(0));
  endtask

  task automatic axi_read(input longint unsigned addr, input int len, input int size, input int stall);
    int n;
    logic [255:0] got, exp, msk;
    logic got_last;
    $display("RD addr=%h len=%0d size=%0d stall=%0d", addr, len, size, stall);
    rd_q.delete();
    m_axi_araddr = addr; m_axi_arlen = 8'(len); m_axi_arsize = 3'(size); m_axi_arvalid = 1'b1;
    n = 0;
    while (!m_axi_arready && n < 50) begin @(posedge clk); #1; n++; end
    check("ar_ready", 256'(m_axi_arready), 256'(1));
    @(posedge clk); #1;
    m_axi_arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      n = 0;
      while (!m_axi_rvalid && n < 50) begin @(posedge clk); #1; n++; end
      if (b == 0) check("rd_latency", 256'(n), 256'(0));
      check("rvalid", 256'(m_axi_rvalid), 256'(1));
      got = m_axi_rdata;
      got_last = m_axi_rlast;
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        check("r_hold_data", m_axi_rdata, got);
        check("r_hold_last", 256'({m_axi_rvalid, m_axi_rlast}), 256'({1'b1, got_last}));
      end
      model_expect(addr + (longint'(b) << size), exp, msk);
      check("rdata", got & msk, exp & msk);
      check("rlast", 256'(got_last), 256'(b == len));
      m_axi_rready = 1'b1;
      @(posedge clk); #1;
      m_axi_rready = 1'b0;
      rd_q.push_back(got);
    end
    check("r_done", 256'({m_axi_arready, m_axi_rvalid}), 256'(2'b10));
  endtask

  task automatic load_beats(input int len, input bit full_strb);
    wr_data_q.delete();
    wr_strb_q.delete();
    for (int b = 0; b <= len; b++) begin
      wr_data_q.push_back(rand256());
      wr_strb_q.push_back(full_strb ? 32'hFFFF_FFFF : $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] v, d, exp, msk;
    longint unsigned a;
    int len, size;

    rst_n = 1'b0;
    m_axi_awvalid = 0; m_axi_awaddr = '0; m_axi_awlen = '0; m_axi_awsize = '0;
    m_axi_wvalid = 0; m_axi_wdata = '0; m_axi_wstrb = '0; m_axi_wlast = 0; m_axi_bready = 0;
    m_axi_arvalid = 0; m_axi_araddr = '0; m_axi_arlen = '0; m_axi_arsize = '0; m_axi_rready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", 256'(ctl_outs()), 256'(0));
    check("rst_rdata", m_axi_rdata, 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ctl", 256'(ctl_outs()), 256'(6'b100100));

    for (int r = 0; r < 48; r++) begin
      load_beats(7, 1'b1);
      axi_write(longint'(r) * 256, 7, 5, 0, 1'b1);
    end

    // Single beat, lane i carries byte value i.
    for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(i);
    wr_data_q = '{d};
    wr_strb_q = '{32'hFFFF_FFFF};
    axi_write(64'h100, 0, 5, 0, 1'b1);
    hier_beat(64'h100, v);
    check("single_store", v, d);
    repeat (5) @(posedge clk);
    #1;
    hier_beat(64'h100, v);
    check("single_hold", v, d);

    axi_read(64'h100, 1, 5, 0);

    wr_data_q = '{rand256()};
    wr_strb_q = '{32'h0000_000F};
    axi_write(64'h200, 0, 5, 0, 1'b1);
    hier_beat(64'h200, v);
    model_expect(64'h200, exp, msk);
    check("strobe_store", v, exp);

    axi_read(64'h300, 2, 5, 3);
    load_beats(0, 1'b1);
    axi_write(64'h400, 0, 5, 3, 1'b1);

    // Copy 256 B from 0x0 to 0x10000 using the data actually read back.
    axi_read(64'h0, 7, 5, 0);
    wr_data_q = rd_q;
    wr_strb_q.delete();
    for (int b = 0; b < 8; b++) wr_strb_q.push_back(32'hFFFF_FFFF);
    axi_write(64'h10000, 7, 5, 0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      hier_beat(64'h10000 + longint'(c) * 32, v);
      model_expect(longint'(c) * 32, exp, msk);
      check("copy", v, exp);
    end
    for (int j = 0; j < 256; j++) model[64'h10000 + longint'(j)] = model[longint'(j)];

    // Upper address bits alias onto the same store bytes.
    load_beats(0, 1'b1);
    axi_write((64'd1 << MEM_AW) + 64'h500, 0, 5, 0, 1'b1);
    hier_beat(64'h500, v);
    check("alias_store", v, wr_data_q[0]);

    for (int t = 0; t < 40; t++) begin
      a = 64'h1000 + longint'($urandom_range(0, 12'hFFF)) + (longint'($urandom_range(0, 3)) << MEM_AW);
      len = $urandom_range(0, 3);
      size = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) begin
        load_beats(len, 1'b0);
        axi_write(a, len, size, $urandom_range(0, 2), 1'b1);
      end else begin
        axi_read(a, len, size, $urandom_range(0, 2));
      end
    end

    // Reset in the middle of a 4-beat write: beat 0 lands, the rest is dropped.
    $display("RST mid-burst write at 0x2800");
    d = rand256();
    m_axi_awaddr = 64'h2800; m_axi_awlen = 8'd3; m_axi_awsize = 3'd5; m_axi_awvalid = 1'b1;
    @(posedge clk); #1;
    m_axi_awvalid = 1'b0;
    m_axi_wdata = d; m_axi_wstrb = 32'hFFFF_FFFF; m_axi_wvalid = 1'b1;
    check("mid_wready", 256'(m_axi_wready), 256'(1));
    @(posedge clk);
    model_write(64'h2800, d, 32'hFFFF_FFFF);
    #1;
    m_axi_wdata = rand256();
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ctl", 256'(ctl_outs()), 256'(0));
    check("rst_mid_rdata", m_axi_rdata, 256'(0));
    m_axi_wvalid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_idle", 256'(ctl_outs()), 256'(6'b100100));
    load_beats(0, 1'b1);
    axi_write(64'h2840, 0, 5, 0, 1'b1);
    axi_read(64'h2800, 2, 5, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
